// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of register-file writeback signals shared by the pipeline, the late unit,
// the decode-stage busy lookup and the register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            pipe_we;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_wdata;
  logic            late_valid;
  logic            late_ready;
  logic [4:0]      late_rd;
  logic [XLEN-1:0] late_wdata;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      r1;
  logic [4:0]      r2;
  logic            busy_r1;
  logic            busy_r2;
  logic            pipe_stall;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;

  modport slave (
    input  pipe_we, pipe_rd, pipe_wdata,
    input  late_valid, late_rd, late_wdata,
    input  issue_valid, issue_rd, r1, r2,
    output late_ready, busy_r1, busy_r2, pipe_stall,
    output rf_we, rf_rd, rf_wdata
  );

  modport master (
    output pipe_we, pipe_rd, pipe_wdata,
    output late_valid, late_rd, late_wdata,
    output issue_valid, issue_rd, r1, r2,
    input  late_ready, busy_r1, busy_r2, pipe_stall,
    input  rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, buffered late results otherwise.
// Define WB_ARB_STARVE_GUARD_EN to add the starvation guard that forces a pipeline bubble.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (FIFO_DEPTH < 2 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("regfile_wb_arbiter: FIFO_DEPTH must be >= 2 and STARVE_LIMIT >= 1");
  end

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
  } wb_entry_t;

  wb_entry_t       mem [FIFO_DEPTH];
  wb_entry_t       head;
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count, count_next;
  logic            late_ready_q;
  logic [31:0]     pending, pending_next;
  logic            empty, push, pop;
  logic            pipe_req, pipe_grant, drain;
  logic            pipe_stall;

  assign empty = (count == '0);
  assign head  = mem[rptr];

  // A write request during reset is suppressed so nothing reaches the register file.
  assign pipe_req   = rst_n && bus.pipe_we && (bus.pipe_rd != 5'd0);
  assign pipe_grant = pipe_req && !pipe_stall;
  assign drain      = !pipe_grant && !empty;
  assign pop        = drain;
  assign push       = bus.late_valid && late_ready_q && (bus.late_rd != 5'd0);

  assign count_next = count + CW'(push) - CW'(pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      late_ready_q <= 1'b1;
      pending      <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count        <= count_next;
      late_ready_q <= (count_next != CW'(FIFO_DEPTH));
      pending      <= pending_next;
    end
  end

  // NOTE: the data array carries no reset; count/pointers gate every read, so
  // stale contents are never observed and the storage stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{rd: bus.late_rd, wdata: bus.late_wdata};
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    pending_next = pending;
    if (drain) pending_next[head.rd] = 1'b0;
    // A new issue to the register being committed keeps it pending (set wins).
    if (bus.issue_valid && bus.issue_rd != 5'd0) pending_next[bus.issue_rd] = 1'b1;
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_rd    = 5'd0;
    bus.rf_wdata = '0;
    if (pipe_grant) begin
      bus.rf_we    = 1'b1;
      bus.rf_rd    = bus.pipe_rd;
      bus.rf_wdata = bus.pipe_wdata;
    end else if (drain) begin
      bus.rf_we    = 1'b1;
      bus.rf_rd    = head.rd;
      bus.rf_wdata = head.wdata;
    end
  end

  // The register file forwards the write data, so busy clears in the commit cycle.
  assign bus.busy_r1 = (bus.r1 != 5'd0) && pending[bus.r1] && !(drain && head.rd == bus.r1);
  assign bus.busy_r2 = (bus.r2 != 5'd0) && pending[bus.r2] && !(drain && head.rd == bus.r2);

  assign bus.late_ready = late_ready_q;
  assign bus.pipe_stall = pipe_stall;

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    S_RUN,
    S_FORCE
  } guard_state_t;

  guard_state_t   state_q, state_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic           blocked;

  assign blocked = !empty && pipe_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pipe_stall = 1'b0;
    case (state_q)
      S_RUN: begin
        if (!blocked) begin
          cnt_d = '0;
        end else if (cnt_q == SCW'(STARVE_LIMIT - 1)) begin
          cnt_d   = '0;
          state_d = S_FORCE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FORCE: begin
        // One-cycle bubble; the head is guaranteed present since nothing popped while blocked.
        pipe_stall = 1'b1;
        cnt_d      = '0;
        state_d    = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end
`else
  assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: late results queued on acceptance and
// checked on commit; busy flags checked against a bench-side pending model.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(
    .XLEN(XLEN),
    .FIFO_DEPTH(2),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] tb_pend = '0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_we     = 1'b0;
    bus.late_valid  = 1'b0;
    bus.issue_valid = 1'b0;
  endtask

  // Commit monitor, pending model and protocol assertions, sampled mid-cycle.
  always @(negedge clk) begin : mon
    logic        grant_pipe;
    logic        drain_now;
    logic [4:0]  drain_rd;
    logic [31:0] nxt;
    wr_t         h;
    if (!rst_n) begin
      exp_q.delete();
      tb_pend = '0;
    end else begin
      grant_pipe = bus.pipe_we && bus.pipe_rd != 5'd0 && !bus.pipe_stall;
      drain_now  = 1'b0;
      drain_rd   = 5'd0;
      if (grant_pipe) begin
        check("pipe_we", bus.rf_we, 1'b1);
        check("pipe_rd", bus.rf_rd, bus.pipe_rd);
        check("pipe_wdata", bus.rf_wdata, bus.pipe_wdata);
        assert (!tb_pend[bus.pipe_rd]) else $error("pipeline write to pending rd %0d", bus.pipe_rd);
      end else if (bus.rf_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", bus.rf_we, 1'b0);
        end else begin
          h = exp_q.pop_front();
          check("late_rd", bus.rf_rd, h.rd);
          check("late_wdata", bus.rf_wdata, h.wdata);
          drain_now = 1'b1;
          drain_rd  = h.rd;
        end
      end else begin
        check("idle_rd", bus.rf_rd, 5'd0);
        check("idle_wdata", bus.rf_wdata, '0);
      end
      check("busy_r1", bus.busy_r1,
            bus.r1 != 5'd0 && tb_pend[bus.r1] && !(drain_now && drain_rd == bus.r1));
      check("busy_r2", bus.busy_r2,
            bus.r2 != 5'd0 && tb_pend[bus.r2] && !(drain_now && drain_rd == bus.r2));
      if (bus.issue_valid && bus.issue_rd != 5'd0)
        assert (!tb_pend[bus.issue_rd] || (drain_now && drain_rd == bus.issue_rd))
          else $error("issue to already pending rd %0d", bus.issue_rd);
      if (bus.late_valid && bus.late_ready && bus.late_rd != 5'd0)
        exp_q.push_back('{rd: bus.late_rd, wdata: bus.late_wdata});
      nxt = tb_pend;
      if (drain_now) nxt[drain_rd] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != 5'd0) nxt[bus.issue_rd] = 1'b1;
      tb_pend = nxt;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.pipe_rd = 5'd0;  bus.pipe_wdata = '0;
    bus.late_rd = 5'd0;  bus.late_wdata = '0;
    bus.issue_rd = 5'd0; bus.r1 = 5'd5; bus.r2 = 5'd0;

    // Reset: a pipeline request during reset must not reach the port.
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_wdata = 32'h55;
    repeat (2) @(negedge clk);
    check("rst_late_ready", bus.late_ready, 1'b1);
    check("rst_rf_we", bus.rf_we, 1'b0);
    check("rst_rf_rd", bus.rf_rd, 5'd0);
    check("rst_rf_wdata", bus.rf_wdata, '0);
    check("rst_pipe_stall", bus.pipe_stall, 1'b0);
    check("rst_busy_r1", bus.busy_r1, 1'b0);
    idle();
    @(posedge clk); #2 rst_n = 1'b1;
    step();

    // Idle drain
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    @(negedge clk); check("issue_busy_late", bus.busy_r1, 1'b0);
    step();
    idle(); bus.late_valid = 1'b1; bus.late_rd = 5'd5; bus.late_wdata = 32'h1234;
    @(negedge clk);
    check("drain_busy_set", bus.busy_r1, 1'b1);
    check("drain_ready", bus.late_ready, 1'b1);
    check("drain_not_same_cycle", bus.rf_we, 1'b0);
    step();
    idle();
    @(negedge clk);
    check("drain_we", bus.rf_we, 1'b1);
    check("drain_rd", bus.rf_rd, 5'd5);
    check("drain_wdata", bus.rf_wdata, 32'h1234);
    check("drain_busy_drop", bus.busy_r1, 1'b0);
    step();
    @(negedge clk); check("drain_busy_after", bus.busy_r1, 1'b0);
    step();

    // Priority: pipeline write beats a buffered late result
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; step();
    idle(); bus.late_valid = 1'b1; bus.late_rd = 5'd9; bus.late_wdata = 32'hB; step();
    idle(); bus.pipe_we = 1'b1; bus.pipe_rd = 5'd7; bus.pipe_wdata = 32'hA;
    @(negedge clk);
    check("prio_pipe_rd", bus.rf_rd, 5'd7);
    check("prio_pipe_wdata", bus.rf_wdata, 32'hA);
    step();
    idle();
    @(negedge clk);
    check("prio_late_we", bus.rf_we, 1'b1);
    check("prio_late_rd", bus.rf_rd, 5'd9);
    check("prio_late_wdata", bus.rf_wdata, 32'hB);
    step();

    // Full FIFO under continuous pipeline writes, then drain and pointer wrap
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd10; step();
    bus.issue_rd = 5'd11; step();
    idle();
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd20; bus.pipe_wdata = 32'd100;
    bus.late_valid = 1'b1; bus.late_rd = 5'd10; bus.late_wdata = 32'hA10;
    @(negedge clk); check("full_ready0", bus.late_ready, 1'b1);
    step();
    bus.pipe_wdata = 32'd101; bus.late_rd = 5'd11; bus.late_wdata = 32'hA11;
    @(negedge clk); check("full_ready1", bus.late_ready, 1'b1);
    step();
    bus.late_valid = 1'b0; bus.pipe_wdata = 32'd102;
    @(negedge clk); check("full_ready_low", bus.late_ready, 1'b0);
    step();
    bus.pipe_wdata = 32'd103;
    @(negedge clk); check("full_ready_held", bus.late_ready, 1'b0);
    step();
    bus.pipe_we = 1'b0;
    @(negedge clk);
    check("full_drain0_rd", bus.rf_rd, 5'd10);
    check("full_drain0_ready", bus.late_ready, 1'b0);
    step();
    @(negedge clk);
    check("full_drain1_rd", bus.rf_rd, 5'd11);
    check("full_ready_back", bus.late_ready, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      bus.late_valid = 1'b1; bus.late_rd = 5'(12 + i); bus.late_wdata = 32'hC00 + i;
      @(negedge clk);
      check("wrap_ready", bus.late_ready, 1'b1);
      if (i > 0) check("wrap_rd", bus.rf_rd, 5'(11 + i));
      step();
    end
    bus.late_valid = 1'b0;
    @(negedge clk); check("wrap_last_rd", bus.rf_rd, 5'd14);
    step();

    // Scoreboard race: re-issue of rd 4 in its own commit cycle
    bus.r1 = 5'd4;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; step();
    idle(); bus.late_valid = 1'b1; bus.late_rd = 5'd4; bus.late_wdata = 32'h44; step();
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    @(negedge clk);
    check("race_commit_rd", bus.rf_rd, 5'd4);
    check("race_busy_commit", bus.busy_r1, 1'b0);
    step();
    idle();
    @(negedge clk); check("race_pending_kept", bus.busy_r1, 1'b1);
    step();
    bus.late_valid = 1'b1; bus.late_rd = 5'd4; bus.late_wdata = 32'h45; step();
    idle();
    @(negedge clk); check("race_clear_wdata", bus.rf_wdata, 32'h45);
    step();

    // Starvation: one buffered entry against continuous pipeline writes
    bus.r1 = 5'd15;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd15; step();
    idle();
    bus.late_valid = 1'b1; bus.late_rd = 5'd15; bus.late_wdata = 32'hF15;
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd22; bus.pipe_wdata = 32'd0;
    step();
    bus.late_valid = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      bus.pipe_wdata = 32'(i);
      @(negedge clk);
`ifdef WB_ARB_STARVE_GUARD_EN
      check("starve_stall", bus.pipe_stall, i == 9);
      if (i == 9) check("starve_drain_rd", bus.rf_rd, 5'd15);
`else
      check("starve_no_stall", bus.pipe_stall, 1'b0);
`endif
      step();
    end
    bus.pipe_we = 1'b0;
    @(negedge clk);
`ifdef WB_ARB_STARVE_GUARD_EN
    check("starve_after_idle", bus.rf_we, 1'b0);
`else
    check("starve_late_drain_rd", bus.rf_rd, 5'd15);
`endif
    step();

    // Async reset with two entries buffered
    bus.r1 = 5'd23;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd23; step();
    idle();
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd20; bus.pipe_wdata = 32'h77;
    bus.late_valid = 1'b1; bus.late_rd = 5'd23; bus.late_wdata = 32'h23;
    step();
    bus.late_rd = 5'd24; bus.late_wdata = 32'h24;
    step();
    bus.late_valid = 1'b0;
    check("pre_reset_full", bus.late_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("areset_rf_we", bus.rf_we, 1'b0);
    check("areset_rf_rd", bus.rf_rd, 5'd0);
    check("areset_late_ready", bus.late_ready, 1'b1);
    check("areset_busy_r1", bus.busy_r1, 1'b0);
    check("areset_pipe_stall", bus.pipe_stall, 1'b0);
    idle();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_no_write", bus.rf_we, 1'b0);
      check("post_reset_busy", bus.busy_r1, 1'b0);
      step();
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
